// File: rtl/dma_in.sv
// Read-direction DMA: fetches DATA_LENGTH words from SDRAM (Wishbone master) and streams them out.
// Define DMA_IN_PREFETCH_EN for a FIFO_DEPTH-word prefetch FIFO; otherwise a single holding register.
module dma_in #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_wbs_stb_i,
    input  logic        s_wbs_cyc_i,
    input  logic        s_wbs_we_i,
    input  logic [3:0]  s_wbs_sel_i,
    input  logic [31:0] s_wbs_adr_i,
    input  logic [31:0] s_wbs_dat_i,
    output logic        s_wbs_ack_o,
    output logic [31:0] s_wbs_dat_o,
    output logic        m_wbs_stb_o,
    output logic        m_wbs_cyc_o,
    output logic        m_wbs_we_o,
    output logic [3:0]  m_wbs_sel_o,
    output logic [31:0] m_wbs_adr_o,
    output logic [31:0] m_wbs_dat_o,
    input  logic        m_wbs_ack_i,
    input  logic [31:0] m_wbs_dat_i,
    output logic        sm_tvalid,
    output logic        sm_tlast,
    output logic [31:0] sm_tdata,
    input  logic        sm_tready
);
`ifdef DMA_IN_PREFETCH_EN
    localparam int CAP = FIFO_DEPTH;
`else
    localparam int CAP = 1;
`endif
    localparam int CW = $clog2(CAP + 1);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic              s_ack_q, s_ack_d;
    logic [31:0]       s_dat_q, s_dat_d;
    logic              start_q, start_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic              cyc_q, cyc_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic [ADDR_W-1:0] nxt_q, nxt_d;
    logic [ADDR_W-1:0] iss_q, iss_d;
    logic [ADDR_W-1:0] snt_q, snt_d;
    logic [CW-1:0]     occ_q, occ_d;

    logic        s_req, busy, push, beat, issue;
    logic [7:0]  off;
    logic [31:0] head;
    logic        unused_ok;

    assign unused_ok = ^{s_wbs_sel_i, s_wbs_adr_i[31:8], 32'(FIFO_DEPTH)};

    assign s_req = s_wbs_stb_i & s_wbs_cyc_i & ~s_ack_q;
    assign off   = s_wbs_adr_i[7:0];
    // A latched start counts as busy so config cannot change under the FSM.
    assign busy  = (state_q != S_IDLE) | start_q;
    assign push  = cyc_q & m_wbs_ack_i;
    assign beat  = sm_tvalid & sm_tready;
    // Wishbone classic: at most one read in flight, so cyc_q is the outstanding count.
    assign issue = (state_q == S_FETCH) & ~cyc_q & (iss_q != len_q) & (occ_q < CW'(CAP));

    always_comb begin
        state_d = state_q;
        s_ack_d = s_req;
        s_dat_d = '0;
        start_d = start_q;
        done_d  = done_q;
        base_d  = base_q;
        len_d   = len_q;
        cyc_d   = cyc_q;
        adr_d   = adr_q;
        nxt_d   = nxt_q;
        iss_d   = iss_q;
        snt_d   = snt_q;
        occ_d   = occ_q + CW'(push) - CW'(beat);

        if (s_req) begin
            if (s_wbs_we_i) begin
                unique case (off)
                    8'h00: if (s_wbs_dat_i[0] && !busy) begin
                        start_d = 1'b1;
                        done_d  = 1'b0;
                    end
                    8'h10: if (!busy) base_d = ADDR_W'(s_wbs_dat_i);
                    8'h20: if (!busy) len_d = ADDR_W'(s_wbs_dat_i);
                    default: ;
                endcase
            end else begin
                unique case (off)
                    8'h00: begin
                        s_dat_d = {29'd0, ~busy, done_q, 1'b0};
                        done_d  = 1'b0;
                    end
                    8'h10: s_dat_d = 32'(base_q);
                    8'h20: s_dat_d = 32'(len_q);
                    default: s_dat_d = '0;
                endcase
            end
        end

        if (push) cyc_d = 1'b0;
        if (beat) snt_d = snt_q + ADDR_W'(1);

        unique case (state_q)
            S_IDLE: if (start_q) begin
                start_d = 1'b0;
                iss_d   = '0;
                snt_d   = '0;
                nxt_d   = base_q;
                state_d = (len_q == '0) ? S_DONE : S_FETCH;
            end
            S_FETCH: begin
                if (issue) begin
                    cyc_d = 1'b1;
                    adr_d = nxt_q;
                    nxt_d = nxt_q + ADDR_W'(4);
                    iss_d = iss_q + ADDR_W'(1);
                end
                if (iss_q == len_q && !cyc_q) state_d = S_DRAIN;
            end
            S_DRAIN: if (snt_q == len_q) state_d = S_DONE;
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            s_ack_q <= 1'b0;
            s_dat_q <= '0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
            base_q  <= '0;
            len_q   <= '0;
            cyc_q   <= 1'b0;
            adr_q   <= '0;
            nxt_q   <= '0;
            iss_q   <= '0;
            snt_q   <= '0;
            occ_q   <= '0;
        end else begin
            state_q <= state_d;
            s_ack_q <= s_ack_d;
            s_dat_q <= s_dat_d;
            start_q <= start_d;
            done_q  <= done_d;
            base_q  <= base_d;
            len_q   <= len_d;
            cyc_q   <= cyc_d;
            adr_q   <= adr_d;
            nxt_q   <= nxt_d;
            iss_q   <= iss_d;
            snt_q   <= snt_d;
            occ_q   <= occ_d;
        end
    end

`ifdef DMA_IN_PREFETCH_EN
    localparam int PW = $clog2(FIFO_DEPTH);
    logic [31:0]   mem_q [FIFO_DEPTH];
    logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;

    always_comb begin
        wp_d = wp_q + PW'(push);
        rp_d = rp_q + PW'(beat);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q <= '{default: '0};
            wp_q  <= '0;
            rp_q  <= '0;
        end else begin
            if (push) mem_q[wp_q] <= m_wbs_dat_i;
            wp_q <= wp_d;
            rp_q <= rp_d;
        end
    end

    assign head = mem_q[rp_q];
`else
    logic [31:0] hold_q, hold_d;

    always_comb hold_d = push ? m_wbs_dat_i : hold_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) hold_q <= '0;
        else      hold_q <= hold_d;
    end

    assign head = hold_q;
`endif

    assign s_wbs_ack_o = s_ack_q;
    assign s_wbs_dat_o = s_dat_q;
    assign m_wbs_stb_o = cyc_q;
    assign m_wbs_cyc_o = cyc_q;
    assign m_wbs_we_o  = 1'b0;
    assign m_wbs_sel_o = 4'hF;
    assign m_wbs_adr_o = 32'(adr_q);
    assign m_wbs_dat_o = '0;
    assign sm_tvalid   = (occ_q != '0);
    assign sm_tdata    = head;
    assign sm_tlast    = sm_tvalid & (snt_q == len_q - ADDR_W'(1));
endmodule

// File: tb/tb_dma_in.sv
// Self-checking bench for dma_in: random SDRAM latency and sink backpressure against a queue-based model.
module tb_dma_in;
`ifdef DMA_IN_PREFETCH_EN
    localparam int CAP = 4;
`else
    localparam int CAP = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        s_stb, s_cyc, s_we;
    logic [3:0]  s_sel;
    logic [31:0] s_adr, s_wdat;
    logic        s_ack;
    logic [31:0] s_rdat;
    logic        m_stb, m_cyc, m_we;
    logic [3:0]  m_sel;
    logic [31:0] m_adr, m_wdat;
    logic        m_ack;
    logic [31:0] m_dat;
    logic        tvalid, tlast, tready;
    logic [31:0] tdata;

    int checks = 0;
    int errors = 0;
    int rdy_mode = 0;
    int acks_n = 0, beats_n = 0, cyc_cycles = 0, wait_n = 0;
    logic [31:0] addr_log[$];
    logic [31:0] dat_log[$];
    logic        last_log[$];

    dma_in dut (
        .clk(clk), .rst(rst),
        .s_wbs_stb_i(s_stb), .s_wbs_cyc_i(s_cyc), .s_wbs_we_i(s_we), .s_wbs_sel_i(s_sel),
        .s_wbs_adr_i(s_adr), .s_wbs_dat_i(s_wdat), .s_wbs_ack_o(s_ack), .s_wbs_dat_o(s_rdat),
        .m_wbs_stb_o(m_stb), .m_wbs_cyc_o(m_cyc), .m_wbs_we_o(m_we), .m_wbs_sel_o(m_sel),
        .m_wbs_adr_o(m_adr), .m_wbs_dat_o(m_wdat), .m_wbs_ack_i(m_ack), .m_wbs_dat_i(m_dat),
        .sm_tvalid(tvalid), .sm_tlast(tlast), .sm_tdata(tdata), .sm_tready(tready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sdram_word(input logic [31:0] a);
        return (a >> 2) - 32'd2;
    endfunction

    // SDRAM responder, stream sink and protocol monitor share one negedge process so
    // the event counters are consistent with each other.
    logic [31:0] held_d;
    logic        held_l;
    bit          stalled = 0;
    initial begin
        m_ack = 1'b0; m_dat = '0; tready = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                m_ack = 1'b0; acks_n = 0; beats_n = 0; stalled = 0;
            end else begin
                if (m_cyc) cyc_cycles++;
                if (m_cyc || tvalid)
                    chk("occ_cap", 32'((acks_n - beats_n + int'(m_cyc)) <= CAP), 32'd1);
                if (stalled) begin
                    chk("hold_valid", {31'd0, tvalid}, 32'd1);
                    chk("hold_data", tdata, held_d);
                    chk("hold_last", {31'd0, tlast}, {31'd0, held_l});
                end
                case (rdy_mode)
                    0: tready = 1'b1;
                    1: tready = 1'($urandom_range(0, 1));
                    default: tready = 1'b0;
                endcase
                stalled = tvalid && !tready;
                held_d  = tdata;
                held_l  = tlast;
                if (tvalid && tready) begin
                    dat_log.push_back(tdata);
                    last_log.push_back(tlast);
                    beats_n++;
                end
                if (m_ack) begin
                    chk("cyc_gap", {31'd0, m_cyc}, 32'd0);
                    m_ack  = 1'b0;
                    wait_n = $urandom_range(0, 4);
                end else if (m_cyc) begin
                    if (wait_n == 0) begin
                        m_ack = 1'b1;
                        m_dat = sdram_word(m_adr);
                        addr_log.push_back(m_adr);
                        acks_n++;
                    end else begin
                        wait_n--;
                    end
                end
            end
        end
    end

    task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] wd,
                           output logic [31:0] rd);
        bit got = 0;
        s_stb = 1'b1; s_cyc = 1'b1; s_we = we; s_adr = adr; s_wdat = wd;
        rd = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (s_ack) begin got = 1; rd = s_rdat; break; end
        end
        s_stb = 1'b0; s_cyc = 1'b0; s_we = 1'b0;
        if (!got) chk("wb_ack_timeout", 32'd0, 32'd1);
    endtask

    task automatic wb_write(input logic [31:0] adr, input logic [31:0] wd);
        logic [31:0] dummy;
        wb_xfer(1'b1, adr, wd, dummy);
    endtask

    task automatic wb_read(input logic [31:0] adr, output logic [31:0] rd);
        wb_xfer(1'b0, adr, 32'd0, rd);
    endtask

    task automatic start_run(input logic [31:0] base, input logic [31:0] len);
        addr_log.delete(); dat_log.delete(); last_log.delete();
        wb_write(32'h10, base);
        wb_write(32'h20, len);
        wb_write(32'h00, 32'd1);
    endtask

    task automatic wait_done(input string tag);
        logic [31:0] v = '0;
        for (int i = 0; i < 3000; i++) begin
            wb_read(32'h00, v);
            if (v[1]) break;
        end
        chk({tag, "_done_read"}, v, 32'h6);
        wb_read(32'h00, v);
        chk({tag, "_done_clear"}, v, 32'h4);
    endtask

    task automatic check_run(input string tag, input logic [31:0] base, input int len);
        logic [31:0] a;
        chk({tag, "_beats"}, 32'(dat_log.size()), 32'(len));
        chk({tag, "_reads"}, 32'(addr_log.size()), 32'(len));
        for (int k = 0; k < len; k++) begin
            a = base + 32'(4 * k);
            if (k < addr_log.size()) chk($sformatf("%s_addr%0d", tag, k), addr_log[k], a);
            if (k < dat_log.size()) begin
                chk($sformatf("%s_data%0d", tag, k), dat_log[k], sdram_word(a));
                chk($sformatf("%s_last%0d", tag, k), {31'd0, last_log[k]}, {31'd0, k == len - 1});
            end
        end
    endtask

    initial begin
        logic [31:0] v;
        int c0;
        bit hit;
        rst = 1'b0; s_stb = 0; s_cyc = 0; s_we = 0; s_sel = 4'hF; s_adr = '0; s_wdat = '0;
        repeat (3) @(negedge clk);
        chk("rst_s_ack", {31'd0, s_ack}, 32'd0);
        chk("rst_s_dat", s_rdat, 32'd0);
        chk("rst_m_cyc", {30'd0, m_cyc, m_stb}, 32'd0);
        chk("rst_m_we", {31'd0, m_we}, 32'd0);
        chk("rst_m_sel", {28'd0, m_sel}, 32'hF);
        chk("rst_m_adr", m_adr, 32'd0);
        chk("rst_m_dat", m_wdat, 32'd0);
        chk("rst_stream", {30'd0, tvalid, tlast}, 32'd0);
        chk("rst_tdata", tdata, 32'd0);
        rst = 1'b1;
        wb_read(32'h00, v); chk("idle_ctrl", v, 32'h4);
        wb_read(32'h44, v); chk("other_off", v, 32'h0);

        // Basic transfer with writes while busy that must be ignored
        rdy_mode = 1;
        start_run(32'd8, 32'd50);
        wb_write(32'h10, 32'h1000);
        wb_write(32'h00, 32'd1);
        wait_done("basic");
        wb_read(32'h10, v); chk("base_kept", v, 32'd8);
        wb_read(32'h20, v); chk("len_read", v, 32'd50);
        check_run("basic", 32'd8, 50);

        // Stalled sink mid-transfer
        start_run(32'h40, 32'd20);
        hit = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (beats_n >= 5) begin hit = 1; break; end
        end
        chk("stall_reach", {31'd0, hit}, 32'd1);
        rdy_mode = 2;
        repeat (30) @(negedge clk);
        chk("stall_no_beats", 32'(dat_log.size() <= 6), 32'd1);
        rdy_mode = 1;
        wait_done("stall");
        check_run("stall", 32'h40, 20);

        // Zero length: no traffic, done within 3 cycles of the start ack
        c0 = cyc_cycles;
        start_run(32'h80, 32'd0);
        repeat (2) @(negedge clk);
        wb_read(32'h00, v); chk("len0_done", v, 32'h6);
        wb_read(32'h00, v); chk("len0_clear", v, 32'h4);
        chk("len0_no_cyc", 32'(cyc_cycles - c0), 32'd0);
        chk("len0_no_beats", 32'(dat_log.size()), 32'd0);

        // Address wrap
        start_run(32'hFFFF_FFF8, 32'd4);
        wait_done("wrap");
        check_run("wrap", 32'hFFFF_FFF8, 4);

        // Reset mid-transfer with a read in flight
        start_run(32'h200, 32'd40);
        hit = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (beats_n >= 10 && m_cyc) begin hit = 1; break; end
        end
        chk("rst_mid_reach", {31'd0, hit}, 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("rstm_cyc", {30'd0, m_cyc, m_stb}, 32'd0);
        chk("rstm_stream", {30'd0, tvalid, tlast}, 32'd0);
        chk("rstm_tdata", tdata, 32'd0);
        chk("rstm_adr", m_adr, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        wb_read(32'h00, v); chk("rstm_ctrl", v, 32'h4);
        wb_read(32'h10, v); chk("rstm_base", v, 32'd0);
        start_run(32'h300, 32'd5);
        wait_done("after_rst");
        check_run("after_rst", 32'h300, 5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dma_in.md
# dma_in

Read-direction DMA engine: fetches a programmed number of 32-bit words from SDRAM over a Wishbone master port and streams them to a user module on an AXI-Stream-like master port. It is the mirror of `dma_out` and shares its control-register map and Wishbone slave behaviour. The CPU configures base address and length through a Wishbone slave port, starts the engine, and polls for done.

## Interface
- `FIFO_DEPTH`, 4: prefetch FIFO entries; power of two, at least 2. Used only when `DMA_IN_PREFETCH_EN` is defined.
- `ADDR_W`, 32: width of the address and length registers.
- `clk` in 1: single clock. All logic is rising-edge.
- `rst` in 1: reset, asynchronous, active-low.
- `s_wbs_stb_i`, `s_wbs_cyc_i`, `s_wbs_we_i` in 1 each: CPU slave request.
- `s_wbs_sel_i` in 4: byte select. Ignored; full-word access only.
- `s_wbs_adr_i` in 32: register offset.
- `s_wbs_dat_i` in 32: write data.
- `s_wbs_ack_o` out 1: slave acknowledge.
- `s_wbs_dat_o` out 32: read data.
- `m_wbs_stb_o`, `m_wbs_cyc_o`, `m_wbs_we_o` out 1 each: SDRAM master request. `m_wbs_we_o` is always 0.
- `m_wbs_sel_o` out 4: constant `4'hF`.
- `m_wbs_adr_o` out 32: SDRAM byte address.
- `m_wbs_dat_o` out 32: constant 0.
- `m_wbs_ack_i` in 1: SDRAM acknowledge.
- `m_wbs_dat_i` in 32: SDRAM read data.
- `sm_tvalid`, `sm_tlast` out 1 each; `sm_tdata` out 32: stream master.
- `sm_tready` in 1: downstream ready.

## Operation
- **Register map** (offset in `s_wbs_adr_i[7:0]`):
  - 0x00 `AP_CTRL`: bit0 ap_start (write 1), bit1 ap_done, bit2 ap_idle.
  - 0x10 `BASE_ADDR`.
  - 0x20 `DATA_LENGTH`, in words.
  - Other offsets read 0; writes to them are ignored.
- **Register access rules:**
  - Writes to `BASE_ADDR` and `DATA_LENGTH` are ignored while busy (ap_idle=0).
  - A write of ap_start while busy is ignored.
  - ap_done is sticky. It is cleared by a read of `AP_CTRL` (the read returns 1) or by a new start.
- **FSM states:**
  - IDLE: ap_idle=1. Start moves to FETCH, or to DONE if the length is 0.
  - FETCH: issue reads while words remain and there is buffer space.
  - DRAIN: all reads have completed; wait until the buffer is empty and the last beat has been accepted.
  - DONE: set ap_done, go to IDLE next cycle.
- **Addressing:** read k uses address `BASE_ADDR + 4*k`, for k = 0..LEN-1. Arithmetic is modulo 2^32 and wraps silently.
- **Data ordering:** words leave on `sm_tdata` in read order. `sm_tlast`=1 only on beat LEN-1.
- **Length 0:** no bus traffic and no stream beats; ap_done is set 2 cycles after the start ack.

## Timing
- **Reset values:** all outputs 0 except `m_wbs_sel_o`=F. Registers reset to 0 and the FSM to IDLE.
- **Reset mid-operation:** aborts immediately. `cyc`/`stb`/`tvalid` drop asynchronously, with no completion and no done.
- **Slave port:**
  - `s_wbs_ack_o` is a 1-cycle pulse, registered 1 cycle after `stb&cyc` is sampled.
  - No new ack is issued in the cycle after an ack, even if `stb` is still high.
  - Write side effects take place on the ack edge.
  - `s_wbs_dat_o` is valid in the ack cycle.
- **Master port:**
  - `cyc`/`stb` assert together, with the address stable, and hold until `m_wbs_ack_i` is sampled high.
  - `m_wbs_dat_i` is captured on the ack edge.
  - `cyc`/`stb` are low for at least 1 cycle between transactions.
  - There is no timeout; ack delay is unbounded.
- **Stream port:**
  - `sm_tvalid` asserts no earlier than the cycle after the data is captured.
  - While `sm_tvalid`=1 and `sm_tready`=0, `sm_tdata`/`sm_tlast` are held stable.
  - A beat transfers on any edge where valid & ready are both high; a new beat may be presented in the next cycle.
- **Simultaneous events:** a FIFO write (ack) and read (beat) in the same cycle are both performed; occupancy is unchanged.
- **Read issue limit:** a read is issued only if occupancy plus outstanding reads is less than capacity, so the FIFO never overflows.
- **Start timing:** a start at the ack edge gives IDLE→FETCH on the following edge.

## Configuration
- `DMA_IN_PREFETCH_EN` defined: FIFO of `FIFO_DEPTH` words. Reads continue while space remains, overlapping with the stream.
- Not defined: a single-word holding register.
  - The next read is issued only after the current word's beat is accepted.
  - Throughput is at most 1 word per (read latency + 2) cycles.
  - The register map and all handshake rules are identical.

## Test plan
- **Basic transfer:** config BASE=8, LEN=50; SDRAM model returns data = address/4 − 2 with random 0–4-cycle ack delay; random `sm_tready`.
  - Required: 50 beats, values 0..49 in order; `tlast` only on beat 49; `m_wbs_adr_o` = 8, 12, …, 204; ap_done=1 afterwards.
- **Stalled sink:** `sm_tready`=0 for 30 cycles mid-transfer.
  - Required: `tdata` stable throughout; at most `FIFO_DEPTH` reads outstanding+buffered (1 without the macro); no data lost.
- **LEN=0:** start.
  - Required: `m_wbs_cyc_o` never asserts, no beats, ap_done=1 within 3 cycles.
- **Register behaviour:**
  - A second start and a `BASE_ADDR` write while busy → ignored; the readback of BASE is unchanged.
  - A read of `AP_CTRL` after done returns 0x6, and the next read returns 0x4.
- **Reset mid-transfer:** assert `rst`=0 after beat 10 with `stb` high.
  - Required: outputs 0 immediately.
  - After re-config with LEN=5, a clean run produces 5 beats.
- **Address wrap:** BASE=0xFFFF_FFF8, LEN=4.
  - Required: addresses FFFF_FFF8, FFFF_FFFC, 0, 4.
